// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file writeback collector.
package rf_wb_pkg;
    localparam int REG_AW = 3;
    localparam int DW     = 32;
    localparam int FW     = 5;
    localparam int NWPORT = 3;
    localparam int NREG   = 1 << REG_AW;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [DW-1:0]     wd;
        logic              wef;
        logic [FW-1:0]     wdf;
    } wb_entry_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic en, input logic [REG_AW-1:0] wa);
        logic [NREG-1:0] m;
        m = '0;
        if (en) m[wa] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/rf_writeback_if.sv
// Per-source result handshake bundle: one valid/ready pair and payload per source.
interface rf_writeback_if #(
    parameter int NSRC = 4
) ();
    import rf_wb_pkg::*;

    logic [NSRC-1:0]        S_VALID;
    logic [NSRC-1:0]        S_READY;
    logic [NSRC-1:0]        S_WE;
    logic [REG_AW*NSRC-1:0] S_WA;
    logic [DW*NSRC-1:0]     S_WD;
    logic [NSRC-1:0]        S_WEF;
    logic [FW*NSRC-1:0]     S_WDF;

    modport master (output S_VALID, S_WE, S_WA, S_WD, S_WEF, S_WDF, input S_READY);
    modport slave  (input S_VALID, S_WE, S_WA, S_WD, S_WEF, S_WDF, output S_READY);
endinterface

// File: rtl/rf_wb_fifo.sv
// Per-source result FIFO with registered ready; exposes its head and a
// pending-write mask covering every occupied slot.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       din,
    output logic            ready,
    input  logic            pop,
    output logic            head_valid,
    output wb_entry_t       head,
    output logic [NREG-1:0] busy,
    output logic            fbusy,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push & ready;
    assign do_pop     = pop & vld[rd_ptr];
    assign head_valid = vld[rd_ptr];
    assign head       = mem[rd_ptr];
    assign empty      = ~|vld;

    always_comb begin
        vld_next    = vld;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (do_pop) begin
            vld_next[rd_ptr] = 1'b0;
            rd_ptr_next      = rd_ptr + PW'(1);
        end
        if (do_push) begin
            vld_next[wr_ptr] = 1'b1;
            wr_ptr_next      = wr_ptr + PW'(1);
        end
    end

    // Ready reflects the slot the next push would land in, so a full FIFO
    // never accepts even when it is being popped on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else begin
            vld    <= vld_next;
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            ready  <= ~vld_next[wr_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_comb begin
        busy  = '0;
        fbusy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k]) begin
                busy  = busy | reg_onehot(mem[k].we, mem[k].wa);
                fbusy = fbusy | mem[k].wef;
            end
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// Writeback collector: round-robin packs up to three conflict-free register
// writes and one flag write per cycle from per-source FIFOs onto the RF ports.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              N_RST,
    rf_writeback_if.slave     src,
    output logic [REG_AW-1:0] WA1,
    output logic [REG_AW-1:0] WA2,
    output logic [REG_AW-1:0] WA3,
    output logic [DW-1:0]     WD1,
    output logic [DW-1:0]     WD2,
    output logic [DW-1:0]     WD3,
    output logic              WE1,
    output logic              WE2,
    output logic              WE3,
    output logic [FW-1:0]     WDF1,
    output logic              WEF1,
    output logic [FW-1:0]     WDF2,
    output logic              WEF2,
    output logic [NREG-1:0]   BUSY,
    output logic              FBUSY,
    output logic              IDLE
);
    localparam int SW = $clog2(NSRC);

    wb_entry_t         head [NSRC];
    logic [NSRC-1:0]   head_valid;
    logic [NSRC-1:0]   grant;
    logic [NSRC-1:0]   fifo_empty;
    logic [NSRC-1:0]   ready_vec;
    logic [NSRC-1:0]   fifo_fbusy;
    logic [NREG-1:0]   fifo_busy [NSRC];

    logic [SW-1:0]     rr;
    logic [SW-1:0]     rr_d;
    logic [NWPORT-1:0] we_d;
    logic [NWPORT-1:0] we_q;
    logic [REG_AW-1:0] wa_d [NWPORT];
    logic [REG_AW-1:0] wa_q [NWPORT];
    logic [DW-1:0]     wd_d [NWPORT];
    logic [DW-1:0]     wd_q [NWPORT];
    logic              flag_we_d;
    logic              flag_we_q;
    logic [FW-1:0]     flag_wd_d;
    logic [FW-1:0]     flag_wd_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        wb_entry_t din;
        assign din.we  = src.S_WE[i];
        assign din.wa  = src.S_WA[REG_AW*i +: REG_AW];
        assign din.wd  = src.S_WD[DW*i +: DW];
        assign din.wef = src.S_WEF[i];
        assign din.wdf = src.S_WDF[FW*i +: FW];

        rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (CLK),
            .rst_n      (N_RST),
            .push       (src.S_VALID[i]),
            .din        (din),
            .ready      (ready_vec[i]),
            .pop        (grant[i]),
            .head_valid (head_valid[i]),
            .head       (head[i]),
            .busy       (fifo_busy[i]),
            .fbusy      (fifo_fbusy[i]),
            .empty      (fifo_empty[i])
        );
    end

    assign src.S_READY = ready_vec;

    // A head is taken whole or not at all; granted register writes fill ports in scan order.
    always_comb begin
        logic [1:0]      nreg;
        logic [NREG-1:0] taken;
        logic [SW-1:0]   idx;
        wb_entry_t       e;
        logic            reg_ok;
        logic            flag_ok;

        grant     = '0;
        we_d      = '0;
        flag_we_d = 1'b0;
        flag_wd_d = '0;
        for (int p = 0; p < NWPORT; p++) begin
            wa_d[p] = '0;
            wd_d[p] = '0;
        end
        nreg    = '0;
        taken   = '0;
        idx     = '0;
        e       = '0;
        reg_ok  = 1'b0;
        flag_ok = 1'b0;

        for (int k = 0; k < NSRC; k++) begin
            idx     = SW'((int'(rr) + k) % NSRC);
            e       = head[idx];
            reg_ok  = !e.we || ((nreg < 2'(NWPORT)) && !taken[e.wa]);
            flag_ok = !e.wef || !flag_we_d;
            if (head_valid[idx] && reg_ok && flag_ok) begin
                grant[idx] = 1'b1;
                if (e.we) begin
                    we_d[nreg] = 1'b1;
                    wa_d[nreg] = e.wa;
                    wd_d[nreg] = e.wd;
                    taken[e.wa] = 1'b1;
                    nreg = nreg + 2'd1;
                end
                if (e.wef) begin
                    flag_we_d = 1'b1;
                    flag_wd_d = e.wdf;
                end
            end
        end

        rr_d = rr;
        if (|grant) rr_d = (rr == SW'(NSRC - 1)) ? '0 : rr + SW'(1);
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            rr        <= '0;
            we_q      <= '0;
            flag_we_q <= 1'b0;
            flag_wd_q <= '0;
            for (int p = 0; p < NWPORT; p++) begin
                wa_q[p] <= '0;
                wd_q[p] <= '0;
            end
        end else begin
            rr        <= rr_d;
            we_q      <= we_d;
            flag_we_q <= flag_we_d;
            flag_wd_q <= flag_wd_d;
            for (int p = 0; p < NWPORT; p++) begin
                wa_q[p] <= wa_d[p];
                wd_q[p] <= wd_d[p];
            end
        end
    end

    assign WE1  = we_q[0];
    assign WE2  = we_q[1];
    assign WE3  = we_q[2];
    assign WA1  = wa_q[0];
    assign WA2  = wa_q[1];
    assign WA3  = wa_q[2];
    assign WD1  = wd_q[0];
    assign WD2  = wd_q[1];
    assign WD3  = wd_q[2];
    assign WEF1 = flag_we_q;
    assign WDF1 = flag_wd_q;
    assign WEF2 = 1'b0;
    assign WDF2 = '0;

    always_comb begin
        BUSY  = '0;
        FBUSY = flag_we_q;
        for (int i = 0; i < NSRC; i++) begin
            BUSY  = BUSY | fifo_busy[i];
            FBUSY = FBUSY | fifo_fbusy[i];
        end
        for (int p = 0; p < NWPORT; p++) begin
            BUSY = BUSY | reg_onehot(we_q[p], wa_q[p]);
        end
    end

    assign IDLE = (&fifo_empty) & ~(|we_q) & ~flag_we_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios and random traffic, with every
// cycle compared against a queue-based reference model of the writeback rules.
module tb_rf_writeback;
    import rf_wb_pkg::*;

    localparam int NSRC  = 4;
    localparam int DEPTH = 2;

    logic        CLK   = 1'b0;
    logic        N_RST = 1'b1;
    logic [2:0]  WA1, WA2, WA3;
    logic [31:0] WD1, WD2, WD3;
    logic        WE1, WE2, WE3;
    logic [4:0]  WDF1, WDF2;
    logic        WEF1, WEF2;
    logic [7:0]  BUSY;
    logic        FBUSY, IDLE;

    rf_writeback_if #(.NSRC(NSRC)) src_if ();

    rf_writeback #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .N_RST (N_RST),
        .src   (src_if),
        .WA1   (WA1),
        .WA2   (WA2),
        .WA3   (WA3),
        .WD1   (WD1),
        .WD2   (WD2),
        .WD3   (WD3),
        .WE1   (WE1),
        .WE2   (WE2),
        .WE3   (WE3),
        .WDF1  (WDF1),
        .WEF1  (WEF1),
        .WDF2  (WDF2),
        .WEF2  (WEF2),
        .BUSY  (BUSY),
        .FBUSY (FBUSY),
        .IDLE  (IDLE)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    // Source stimulus waiting to be offered, and the model's view of FIFO contents.
    wb_entry_t       stim [NSRC][$];
    wb_entry_t       mq   [NSRC][$];
    logic [NSRC-1:0] m_ready;
    int              m_rr;
    logic [2:0]      m_we;
    logic [2:0]      m_wa [3];
    logic [31:0]     m_wd [3];
    logic            m_wef;
    logic [4:0]      m_wdf;

    logic [31:0]     rf_obs [8];
    logic [31:0]     wd_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wb_entry_t ent(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                                      input logic wef, input logic [4:0] wdf);
        wb_entry_t e;
        e.we  = we;
        e.wa  = wa;
        e.wd  = wd;
        e.wef = wef;
        e.wdf = wdf;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            mq[i].delete();
            stim[i].delete();
        end
        m_ready = '0;
        m_rr    = 0;
        m_we    = '0;
        m_wef   = 1'b0;
        m_wdf   = '0;
        for (int p = 0; p < 3; p++) begin
            m_wa[p] = '0;
            m_wd[p] = '0;
        end
    endtask

    function automatic bit model_idle();
        bit r;
        r = (m_we == 3'b000) && !m_wef;
        for (int i = 0; i < NSRC; i++) begin
            if (mq[i].size() != 0 || stim[i].size() != 0) r = 0;
        end
        return r;
    endfunction

    // One clock edge of the reference: heads compete from m_rr upward, the
    // registered outputs become the grants, then new offers join the queues.
    task automatic model_edge();
        wb_entry_t writes [$];
        logic [7:0] claimed;
        bit flag_taken;
        bit any;
        claimed    = '0;
        flag_taken = 0;
        any        = 0;
        m_we       = '0;
        m_wef      = 1'b0;
        m_wdf      = '0;
        for (int p = 0; p < 3; p++) begin
            m_wa[p] = '0;
            m_wd[p] = '0;
        end
        for (int k = 0; k < NSRC; k++) begin
            int s;
            s = (m_rr + k) % NSRC;
            if (mq[s].size() != 0) begin
                wb_entry_t e;
                bit reg_fits;
                bit flag_fits;
                e         = mq[s][0];
                reg_fits  = !e.we || (writes.size() < 3 && !claimed[e.wa]);
                flag_fits = !e.wef || !flag_taken;
                if (reg_fits && flag_fits) begin
                    void'(mq[s].pop_front());
                    any = 1;
                    if (e.we) begin
                        writes.push_back(e);
                        claimed[e.wa] = 1'b1;
                    end
                    if (e.wef) begin
                        flag_taken = 1;
                        m_wef      = 1'b1;
                        m_wdf      = e.wdf;
                    end
                end
            end
        end
        foreach (writes[n]) begin
            m_we[n] = 1'b1;
            m_wa[n] = writes[n].wa;
            m_wd[n] = writes[n].wd;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (stim[i].size() != 0 && m_ready[i]) mq[i].push_back(stim[i][0]);
        end
        for (int i = 0; i < NSRC; i++) m_ready[i] = (mq[i].size() < DEPTH);
        if (any) m_rr = (m_rr + 1) % NSRC;
    endtask

    task automatic check_outputs();
        logic [7:0]  eb;
        logic        ef;
        logic        eidle;
        logic [2:0]  dwe;
        logic [2:0]  dwa [3];
        logic [31:0] dwd [3];
        eb    = '0;
        ef    = m_wef;
        eidle = (m_we == 3'b000) && !m_wef;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = 0; j < mq[i].size(); j++) begin
                if (mq[i][j].we) eb[mq[i][j].wa] = 1'b1;
                if (mq[i][j].wef) ef = 1'b1;
            end
            if (mq[i].size() != 0) eidle = 1'b0;
        end
        for (int p = 0; p < 3; p++) if (m_we[p]) eb[m_wa[p]] = 1'b1;
        dwe = {WE3, WE2, WE1};
        dwa = '{WA1, WA2, WA3};
        dwd = '{WD1, WD2, WD3};
        for (int p = 0; p < 3; p++) begin
            check($sformatf("WE%0d", p + 1), dwe[p], m_we[p]);
            if (m_we[p]) begin
                check($sformatf("WA%0d", p + 1), dwa[p], m_wa[p]);
                check($sformatf("WD%0d", p + 1), dwd[p], m_wd[p]);
            end
        end
        check("WEF1", WEF1, m_wef);
        if (m_wef) check("WDF1", WDF1, m_wdf);
        check("BUSY", BUSY, eb);
        check("FBUSY", FBUSY, ef);
        check("IDLE", IDLE, eidle);
        check("S_READY", src_if.S_READY, m_ready);
    endtask

    task automatic step();
        logic [NSRC-1:0]   v, we, wef, acc;
        logic [3*NSRC-1:0] wa;
        logic [32*NSRC-1:0] wd;
        logic [5*NSRC-1:0] wdf;
        v = '0; we = '0; wef = '0; wa = '0; wd = '0; wdf = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (stim[i].size() != 0) begin
                v[i]          = 1'b1;
                we[i]         = stim[i][0].we;
                wa[3*i +: 3]  = stim[i][0].wa;
                wd[32*i +: 32] = stim[i][0].wd;
                wef[i]        = stim[i][0].wef;
                wdf[5*i +: 5] = stim[i][0].wdf;
            end
        end
        src_if.S_VALID = v;
        src_if.S_WE    = we;
        src_if.S_WA    = wa;
        src_if.S_WD    = wd;
        src_if.S_WEF   = wef;
        src_if.S_WDF   = wdf;
        acc = v & src_if.S_READY;
        if (WE1) begin rf_obs[WA1] = WD1; wd_log.push_back(WD1); end
        if (WE2) begin rf_obs[WA2] = WD2; wd_log.push_back(WD2); end
        if (WE3) begin rf_obs[WA3] = WD3; wd_log.push_back(WD3); end
        model_edge();
        @(posedge CLK);
        #1;
        for (int i = 0; i < NSRC; i++) if (acc[i]) void'(stim[i].pop_front());
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        N_RST = 1'b0;
        model_reset();
        src_if.S_VALID = '0;
        #1;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
            #1;
            check_outputs();
        end
        N_RST = 1'b1;
        #1;
        check("S_READY_at_release", src_if.S_READY, '0);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 80; c++) begin
            if (model_idle()) break;
            step();
        end
        check({tag, "_idle"}, IDLE, 1'b1);
    endtask

    initial begin
        src_if.S_VALID = '0;
        src_if.S_WE    = '0;
        src_if.S_WA    = '0;
        src_if.S_WD    = '0;
        src_if.S_WEF   = '0;
        src_if.S_WDF   = '0;
        for (int r = 0; r < 8; r++) rf_obs[r] = '0;
        #2;

        // Reset held three cycles, then ready rises one edge after release.
        do_reset(3);
        check("reset_WEF2", WEF2, 1'b0);
        check("reset_WDF2", WDF2, 5'h00);
        step();
        check("ready_first_edge", src_if.S_READY, 4'hF);

        // Reset pulse with two entries queued discards them.
        stim[0].push_back(ent(1'b1, 3'd1, 32'h1111_0000, 1'b0, 5'h0));
        stim[1].push_back(ent(1'b1, 3'd2, 32'h2222_0000, 1'b1, 5'h3));
        step();
        do_reset(2);
        for (int c = 0; c < 4; c++) step();
        check("pulse_busy_clear", BUSY, 8'h00);

        // Single write timing.
        stim[0].push_back(ent(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 5'h0));
        step();
        check("single_busy_k", BUSY[3], 1'b1);
        check("single_we1_k", WE1, 1'b0);
        step();
        check("single_we1", WE1, 1'b1);
        check("single_wa1", WA1, 3'd3);
        check("single_wd1", WD1, 32'hDEADBEEF);
        check("single_we2", WE2, 1'b0);
        check("single_we3", WE3, 1'b0);
        check("single_busy_k1", BUSY[3], 1'b1);
        step();
        check("single_we1_off", WE1, 1'b0);
        check("single_busy_k2", BUSY[3], 1'b0);

        // Four sources in one cycle: three ports, then the fourth.
        do_reset(1);
        step();
        for (int i = 0; i < NSRC; i++)
            stim[i].push_back(ent(1'b1, 3'(i + 1), 32'hA0 + 32'(i), 1'b0, 5'h0));
        step();
        step();
        check("four_we", {WE3, WE2, WE1}, 3'b111);
        check("four_wa", {WA3, WA2, WA1}, {3'd3, 3'd2, 3'd1});
        step();
        check("four_c2_we", {WE3, WE2, WE1}, 3'b001);
        check("four_c2_wa1", WA1, 3'd4);
        step();
        check("four_idle", IDLE, 1'b1);

        // Same-address conflict is serialised.
        do_reset(1);
        step();
        stim[0].push_back(ent(1'b1, 3'd5, 32'h11, 1'b0, 5'h0));
        stim[1].push_back(ent(1'b1, 3'd5, 32'h22, 1'b0, 5'h0));
        step();
        step();
        check("conf_c1", {WE2, WE1, WD1}, {1'b0, 1'b1, 32'h11});
        step();
        check("conf_c2", {WE2, WE1, WD1}, {1'b0, 1'b1, 32'h22});
        step();
        check("conf_reg5", rf_obs[5], 32'h22);

        // Flag conflict defers the whole second entry.
        do_reset(1);
        step();
        stim[0].push_back(ent(1'b1, 3'd2, 32'h2, 1'b1, 5'h01));
        stim[2].push_back(ent(1'b1, 3'd6, 32'h6, 1'b1, 5'h1F));
        step();
        step();
        check("flag_c1", {WEF1, WDF1, WE2, WE1, WA1}, {1'b1, 5'h01, 1'b0, 1'b1, 3'd2});
        step();
        check("flag_c2", {WEF1, WDF1, WE2, WE1, WA1}, {1'b1, 5'h1F, 1'b0, 1'b1, 3'd6});
        check("flag_fbusy_c2", FBUSY, 1'b1);
        step();
        check("flag_fbusy_clear", FBUSY, 1'b0);

        // Backpressure on source 1 while flag-only traffic saturates the flag slot.
        do_reset(1);
        step();
        wd_log.delete();
        for (int n = 0; n < 3; n++) begin
            stim[0].push_back(ent(1'b0, 3'd0, 32'h0, 1'b1, 5'(n)));
            stim[1].push_back(ent(1'b1, 3'd7, 32'hB000_0001 + 32'(n), 1'b1, 5'h0A));
            stim[2].push_back(ent(1'b0, 3'd0, 32'h0, 1'b1, 5'(n + 8)));
            stim[3].push_back(ent(1'b0, 3'd0, 32'h0, 1'b1, 5'(n + 16)));
        end
        step();
        step();
        check("bp_ready1_low", src_if.S_READY[1], 1'b0);
        drain("bp");
        check("bp_count", 64'(wd_log.size()), 64'd3);
        if (wd_log.size() == 3) begin
            for (int n = 0; n < 3; n++)
                check($sformatf("bp_order%0d", n), wd_log[n], 32'hB000_0001 + 32'(n));
        end

        // Random traffic, including one reset in the middle.
        do_reset(1);
        step();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                do_reset(2);
            end
            for (int i = 0; i < NSRC; i++) begin
                if (stim[i].size() < 2 && $urandom_range(0, 1) == 1)
                    stim[i].push_back(ent(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                                          32'($urandom), 1'($urandom_range(0, 3) == 0),
                                          5'($urandom_range(0, 31))));
            end
            step();
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writeback collector on the write side of the 8x32 register file.
- Accepts completed results from NSRC execution units through valid/ready handshakes, with one small FIFO per source.
- Each cycle it packs up to three non-conflicting register writes and one flag write onto the register file's WA/WD/WE 1..3 and WDF1/WEF1 ports.
- Exports a pending-write scoreboard (BUSY/FBUSY) for decode hazard checks.

Parameters:
- NSRC, 4, number of result sources (2..8).
- DEPTH, 2, entries per source FIFO (power of two, >=2).

Ports:
- CLK  in  1  clock.
- N_RST  in  1  reset.
- S_VALID  in  NSRC  per-source result valid.
- S_READY  out  NSRC  per-source FIFO can accept.
- S_WE  in  NSRC  entry writes a register.
- S_WA  in  3*NSRC  register address, source i at [3i+2:3i].
- S_WD  in  32*NSRC  register data.
- S_WEF  in  NSRC  entry writes flags.
- S_WDF  in  5*NSRC  flag data.
- WA1/WA2/WA3  out  3  register file write addresses.
- WD1/WD2/WD3  out  32  register file write data.
- WE1/WE2/WE3  out  1  register file write enables.
- WDF1  out  5  flag data.
- WEF1  out  1  flag write enable. WDF2/WEF2 are tied low at top level.
- BUSY  out  8  register r has a write pending in a FIFO or in the output stage.
- FBUSY  out  1  a flag write is pending.
- IDLE  out  1  all FIFOs empty and no output enable set.

Behaviour:
- Clock and reset: one clock, CLK; reset N_RST, asynchronous, active-low.
- Reset state:
  - FIFOs emptied; round-robin pointer RR=0.
  - WE1..3=0, WEF1=0, WA*/WD*/WDF1=0.
  - S_READY=0; BUSY=0, FBUSY=0, IDLE=1.
  - S_READY is registered: it becomes 1 at the first CLK edge after reset release.
- Reset mid-operation: all pending entries are discarded; no write enable is asserted after N_RST falls.
- Enqueue:
  - Transfer occurs on S_VALID[i]&S_READY[i] at a rising edge.
  - S_READY[i] = registered "count<DEPTH" for the next cycle.
  - No enqueue into a full FIFO, even if it dequeues in the same cycle.
  - No bypass: an entry is visible for arbitration only from the cycle after enqueue.
  - An entry with S_WE=0 and S_WEF=0 is accepted and retired at arbitration without using a slot.
- Arbitration (combinational, per cycle):
  - Only FIFO heads compete; one grant per source per cycle, so per-source order is preserved.
  - Sources are scanned from RR upward, mod NSRC.
  - A head is granted only if all of the following hold:
    - a port slot is free (max 3), when S_WE=1;
    - its WA differs from every WA already granted this cycle;
    - the flag slot is free, when S_WEF=1.
  - Grants are atomic: if either the register part or the flag part is blocked, the whole entry is deferred.
  - The n-th granted register write drives port n (1..3). WA values on asserted ports are therefore always distinct, so register file write priority never matters.
- Output stage:
  - Registered. Accept edge N → port enables asserted after edge N+1 at the earliest → register file updated at edge N+2.
  - Enables are high for exactly one cycle per grant.
- RR advances by one, mod NSRC, in each cycle with at least one grant.
- BUSY/FBUSY are combinational OR over all valid FIFO entries plus the output-stage enables. They clear in the cycle after the final write edge.
- Cross-source write-after-write to the same register is ordered only by arbitration. Issue logic must stall on BUSY; the block does not reorder.

Decomposition:
- Package rf_wb_pkg:
  - Constants: REG_AW=3, DW=32, FW=5, NWPORT=3.
  - Struct wb_entry_t {we, wa, wd, wef, wdf}.
- Sub-module rf_wb_fifo: one instance per source, DEPTH entries, registered ready, head/valid outputs, pop input.
- Arbiter and output stage live in rf_writeback.

Test Plan:
- Reset: hold N_RST low for 3 cycles.
  → All enables 0, S_READY=0, IDLE=1. S_READY goes all-ones one edge after release. Pulse N_RST low with 2 entries queued → no WE seen afterwards, BUSY=0.
- Single write: src0 WE=1, WA=3, WD=32'hDEADBEEF accepted at edge k.
  → WE1=1, WA1=3, WD1=DEADBEEF after edge k+1, for one cycle; WE2=WE3=0. BUSY[3]=1 from after edge k until after edge k+2.
- Four sources, WA=1/2/3/4, same cycle, RR=0.
  → Cycle 1: ports 1..3 carry addresses 1, 2, 3. Cycle 2: WE1 with WA1=4. IDLE=1 afterwards.
- Address conflict: src0 and src1 both WA=5, WD=32'h11 and 32'h22, RR=0.
  → 32'h11 on port 1 first; 32'h22 on port 1 the next cycle. Never both in one cycle. Register 5 ends at 32'h22.
- Flag conflict: src0 WEF=1 WDF=5'h01 WA=2; src2 WEF=1 WDF=5'h1F WA=6.
  → Cycle 1: WEF1 with 5'h01 and WA1=2 only. Cycle 2: WEF1 with 5'h1F and WA1=6. FBUSY drops after the final write edge.
- Backpressure: src1 pushes 3 entries while src0/src2/src3 heads saturate arbitration and RR favours them (DEPTH=2).
  → S_READY[1] deasserts after 2 accepts. The 3rd entry is held until ready returns. All 3 entries are written in push order.
